// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser behind a byte-oriented UART receiver: A5 | LEN | payload | CHK.
// Valid frames are held in a payload buffer until the consumer acknowledges them.
module uart_rx_frame_ctrl #(
  parameter int unsigned c_clkfreq   = 100_000_000,
  parameter int unsigned c_baudrate  = 115_200,
  parameter int unsigned c_max_len   = 16,
  parameter int unsigned c_tout_bits = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_tick_i,
  output logic       frame_valid_o,
  output logic [7:0] frame_len_o,
  input  logic [7:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  input  logic       frame_ack_i,
  output logic       err_chk_o,
  output logic       err_len_o,
  output logic       err_tout_o,
  output logic       err_ovf_o
);

  localparam longint unsigned TOUT_L =
    64'(c_tout_bits) * 64'(c_clkfreq) / 64'(c_baudrate);
  localparam int unsigned TOUT_LIM = (TOUT_L < 64'd1) ? 1 : 32'(TOUT_L);
  localparam int unsigned CW       = $clog2(TOUT_LIM + 1);
  localparam int unsigned IW       = $clog2(c_max_len + 1);
  localparam int unsigned AW       = (c_max_len > 1) ? $clog2(c_max_len) : 1;
  localparam logic [7:0]  HDR      = 8'hA5;
  localparam logic [7:0]  MAXLEN8  = 8'(c_max_len);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      sum_q, sum_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            err_chk_q, err_chk_d;
  logic            err_len_q, err_len_d;
  logic            err_tout_q, err_tout_d;
  logic            err_ovf_q, err_ovf_d;

  logic            buf_we;
  logic [AW-1:0]   buf_waddr;
  logic [7:0]      mem_q [c_max_len];
  logic            timed;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    cnt_d      = '0;
    err_chk_d  = 1'b0;
    err_len_d  = 1'b0;
    err_tout_d = 1'b0;
    err_ovf_d  = 1'b0;
    buf_we     = 1'b0;
    buf_waddr  = idx_q[AW-1:0];
    timed      = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);

    // A received byte always restarts the inter-byte timer, so it wins over a timeout.
    if (timed && !rx_done_tick_i) begin
      if (cnt_q == CW'(TOUT_LIM - 1)) begin
        err_tout_d = 1'b1;
        state_d    = S_IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (rx_done_tick_i && rx_data_i == HDR) state_d = S_LEN;
      end
      S_LEN: begin
        if (rx_done_tick_i) begin
          if (rx_data_i != 8'h00 && rx_data_i <= MAXLEN8) begin
            len_d   = rx_data_i;
            idx_d   = '0;
            sum_d   = '0;
            state_d = S_PAYLOAD;
          end else begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_done_tick_i) begin
          buf_we = 1'b1;
          idx_d  = idx_q + IW'(1);
          sum_d  = sum_q + rx_data_i;
          if (8'(idx_q) == len_q - 8'd1) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (rx_done_tick_i) begin
          if (rx_data_i == 8'(len_q + sum_q)) begin
            state_d = S_HOLD;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        // A byte arriving with the ack is handled as if the block were already idle.
        if (frame_ack_i) begin
          state_d = (rx_done_tick_i && rx_data_i == HDR) ? S_LEN : S_IDLE;
        end else if (rx_done_tick_i) begin
          err_ovf_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rd_data_d = (rd_addr_i < MAXLEN8) ? mem_q[rd_addr_i[AW-1:0]] : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      err_chk_q  <= 1'b0;
      err_len_q  <= 1'b0;
      err_tout_q <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      err_chk_q  <= err_chk_d;
      err_len_q  <= err_len_d;
      err_tout_q <= err_tout_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  // Payload storage carries no reset; its contents only matter while a frame is held.
  always_ff @(posedge clk) begin
    if (buf_we) mem_q[buf_waddr] <= rx_data_i;
  end

  assign frame_valid_o = (state_q == S_HOLD);
  assign frame_len_o   = len_q;
  assign rd_data_o     = rd_data_q;
  assign err_chk_o     = err_chk_q;
  assign err_len_o     = err_len_q;
  assign err_tout_o    = err_tout_q;
  assign err_ovf_o     = err_ovf_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed frame scenarios plus randomized frames
// whose expected outcome is derived from the frame format rules.
module tb_uart_rx_frame_ctrl;

  localparam int MAXL = 16;
  localparam int LIM  = int'(64'd20 * 64'd100_000_000 / 64'd115200);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_tick = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  logic       frame_ack = 1'b0;
  logic       frame_valid;
  logic [7:0] frame_len;
  logic [7:0] rd_data;
  logic       err_chk, err_len, err_tout, err_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int n_chk = 0, n_len = 0, n_tout = 0, n_ovf = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pay[$];

  uart_rx_frame_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_data_i      (rx_data),
    .rx_done_tick_i (rx_tick),
    .frame_valid_o  (frame_valid),
    .frame_len_o    (frame_len),
    .rd_addr_i      (rd_addr),
    .rd_data_o      (rd_data),
    .frame_ack_i    (frame_ack),
    .err_chk_o      (err_chk),
    .err_len_o      (err_len),
    .err_tout_o     (err_tout),
    .err_ovf_o      (err_ovf)
  );

  always #5 clk = ~clk;

  // Error pulse monitor: counts pulses and checks they never overlap.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_chk)  n_chk++;
      if (err_len)  n_len++;
      if (err_tout) n_tout++;
      if (err_ovf)  n_ovf++;
      if (err_chk || err_len || err_tout || err_ovf) begin
        n_checks++;
        assert ($onehot({err_chk, err_len, err_tout, err_ovf})) else begin
          n_errors++;
          $error("FAIL err_onehot: observed %b expected one-hot",
                 {err_chk, err_len, err_tout, err_ovf});
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents one byte strobe for one cycle; returns on the following falling edge.
  task automatic send(input logic [7:0] b, input logic ack);
    rx_data   = b;
    rx_tick   = 1'b1;
    frame_ack = ack;
    @(negedge clk);
    rx_tick   = 1'b0;
    frame_ack = 1'b0;
  endtask

  function automatic logic [7:0] chk_of(input logic [7:0] len_b);
    logic [7:0] s;
    s = len_b;
    foreach (pay[i]) s = s + pay[i];
    return s;
  endfunction

  task automatic send_frame(input logic hdr, input logic [7:0] len_b,
                            input logic [7:0] chk_b, input int max_gap);
    if (hdr) begin
      send(8'hA5, 1'b0);
      idle($urandom_range(0, max_gap));
    end
    send(len_b, 1'b0);
    foreach (pay[i]) begin
      idle($urandom_range(0, max_gap));
      send(pay[i], 1'b0);
    end
    idle($urandom_range(0, max_gap));
    send(chk_b, 1'b0);
  endtask

  task automatic read_payload(input string tag);
    exp_q = pay;
    for (int i = 0; i < pay.size(); i++) begin
      rd_addr = 8'(i);
      @(negedge clk);
      check(tag, rd_data, exp_q.pop_front());
    end
  endtask

  // Called right after the CHK byte: the frame must be visible on this edge.
  task automatic expect_frame(input string tag);
    check({tag, "_valid"}, frame_valid, 1'b1);
    check({tag, "_len"}, frame_len, pay.size());
    read_payload({tag, "_data"});
    rd_addr = 8'(MAXL);
    @(negedge clk);
    check({tag, "_rd_oob"}, rd_data, 8'h00);
    rd_addr = 8'hFF;
    @(negedge clk);
    check({tag, "_rd_ff"}, rd_data, 8'h00);
    check({tag, "_still_valid"}, frame_valid, 1'b1);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    check({tag, "_ack_clears"}, frame_valid, 1'b0);
  endtask

  initial begin
    int c0, l0, t0, o0, k, kind, len;
    logic [7:0] b, chk;

    // Reset state
    idle(3);
    check("rst_valid", frame_valid, 1'b0);
    check("rst_len", frame_len, 8'h00);
    check("rst_rd", rd_data, 8'h00);
    check("rst_errs", {err_chk, err_len, err_tout, err_ovf}, 4'h0);
    rst_n = 1'b1;
    idle(2);

    // Reference frame A5 03 D2 01 FF D5
    pay = '{8'hD2, 8'h01, 8'hFF};
    send_frame(1'b1, 8'h03, 8'hD5, 0);
    expect_frame("ref");

    // Bad checksum followed by a good frame
    c0 = n_chk;
    send_frame(1'b1, 8'h03, 8'hD4, 2);
    check("badchk_valid", frame_valid, 1'b0);
    idle(2);
    check("badchk_pulse", n_chk - c0, 1);
    pay = '{8'h7F};
    send_frame(1'b1, 8'h01, 8'h80, 1);
    expect_frame("after_badchk");

    // Length errors: zero and max+1
    l0 = n_len;
    send(8'hA5, 1'b0); send(8'h00, 1'b0);
    send(8'hA5, 1'b0); send(8'h11, 1'b0);
    idle(3);
    check("len_pulses", n_len - l0, 2);
    check("len_no_frame", frame_valid, 1'b0);

    // Maximum length with header bytes inside the payload
    pay = {};
    for (int i = 0; i < MAXL; i++) pay.push_back((i % 3 == 0) ? 8'hA5 : 8'($urandom));
    send_frame(1'b1, 8'(MAXL), chk_of(8'(MAXL)), 1);
    expect_frame("maxlen");

    // Inter-byte timeout
    t0 = n_tout;
    send(8'hA5, 1'b0); send(8'h02, 1'b0); send(8'h33, 1'b0);
    k = 0;
    while (k < LIM + 50) begin
      @(negedge clk);
      k++;
      if (err_tout) break;
    end
    check("tout_latency", (k >= LIM - 2) && (k <= LIM + 2), 1'b1);
    idle(2);
    check("tout_pulse", n_tout - t0, 1);
    check("tout_no_frame", frame_valid, 1'b0);
    pay = '{8'h44};
    send_frame(1'b1, 8'h01, 8'h45, 0);
    expect_frame("after_tout");

    // Overflow while holding, then ack coinciding with a new header
    o0 = n_ovf;
    pay = '{8'h10, 8'h20};
    send_frame(1'b1, 8'h02, 8'h32, 1);
    check("hold_valid", frame_valid, 1'b1);
    send(8'h55, 1'b0);
    idle(2);
    check("ovf_pulse", n_ovf - o0, 1);
    check("ovf_valid", frame_valid, 1'b1);
    check("ovf_len", frame_len, 8'h02);
    read_payload("ovf_buf");
    send(8'hA5, 1'b1);
    check("ack_hdr_valid", frame_valid, 1'b0);
    pay = '{8'h7F};
    send_frame(1'b0, 8'h01, 8'h80, 0);
    expect_frame("ack_hdr_frame");
    idle(2);
    check("ack_hdr_no_ovf", n_ovf - o0, 1);

    // Reset mid-frame, then orphan payload bytes
    send(8'hA5, 1'b0); send(8'h02, 1'b0); send(8'h11, 1'b0);
    rst_n = 1'b0;
    idle(2);
    check("midrst_valid", frame_valid, 1'b0);
    check("midrst_len", frame_len, 8'h00);
    check("midrst_rd", rd_data, 8'h00);
    check("midrst_errs", {err_chk, err_len, err_tout, err_ovf}, 4'h0);
    rst_n = 1'b1;
    idle(1);
    c0 = n_chk; l0 = n_len; t0 = n_tout; o0 = n_ovf;
    send(8'h22, 1'b0); send(8'h33, 1'b0);
    idle(4);
    check("postrst_valid", frame_valid, 1'b0);
    check("postrst_errs", (n_chk - c0) + (n_len - l0) + (n_tout - t0) + (n_ovf - o0), 0);

    // Randomized frames
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, MAXL);
      pay  = {};
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
      chk  = chk_of(8'(len));
      c0 = n_chk; l0 = n_len;
      case (kind)
        0: begin
          send_frame(1'b1, 8'(len), chk, 4);
          expect_frame("rnd_good");
        end
        1: begin
          send_frame(1'b1, 8'(len), chk ^ 8'($urandom_range(1, 255)), 4);
          check("rnd_badchk_valid", frame_valid, 1'b0);
          idle(2);
          check("rnd_badchk_pulse", n_chk - c0, 1);
        end
        2: begin
          b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255));
          send(8'hA5, 1'b0);
          idle($urandom_range(0, 4));
          send(b, 1'b0);
          idle(2);
          check("rnd_badlen_pulse", n_len - l0, 1);
          check("rnd_badlen_valid", frame_valid, 1'b0);
        end
        default: begin
          for (int g = 0; g < 4; g++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            send(b, 1'b0);
          end
          send_frame(1'b1, 8'(len), chk, 4);
          expect_frame("rnd_garbage");
          idle(1);
          check("rnd_garbage_noerr", (n_chk - c0) + (n_len - l0), 0);
        end
      endcase
      idle(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 The block SHALL have parameter c_clkfreq, default 100_000_000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter c_baudrate, default 115_200, UART bit rate.
REQ-003 The block SHALL have parameter c_max_len, default 16, maximum payload bytes (1..255).
REQ-004 The block SHALL have parameter c_tout_bits, default 20, inter-byte timeout in bit periods.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 The block SHALL have these ports, clock and reset first:
  clk  in  1  system clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  rx_data_i  in  8  received byte from uart_rx dout_o
  rx_done_tick_i  in  1  one-cycle strobe from uart_rx rx_done_tick_o; rx_data_i valid this cycle
  frame_valid_o  out  1  complete, checksum-correct frame held in buffer
  frame_len_o  out  8  payload length of held frame
  rd_addr_i  in  8  payload buffer read address
  rd_data_o  out  8  payload byte at rd_addr_i, registered
  frame_ack_i  in  1  consumer releases held frame
  err_chk_o  out  1  one-cycle pulse, checksum mismatch
  err_len_o  out  1  one-cycle pulse, LEN = 0 or LEN > c_max_len
  err_tout_o  out  1  one-cycle pulse, inter-byte timeout
  err_ovf_o  out  1  one-cycle pulse, byte dropped while frame held

Function
REQ-007 Frame format SHALL be: 0xA5 header, LEN byte, LEN payload bytes, CHK byte; CHK = (LEN + sum of payload) mod 256.
REQ-008 The FSM SHALL have states IDLE, LEN, PAYLOAD, CHK, HOLD; each state changes only on rx_done_tick_i, timeout, or frame_ack_i.
REQ-009 IDLE: byte 0xA5 -> LEN; any other byte SHALL be discarded silently, no error.
REQ-010 LEN: LEN in 1..c_max_len -> store length, clear byte index and running sum, go PAYLOAD; otherwise pulse err_len_o and go IDLE.
REQ-011 PAYLOAD: each byte SHALL be written to buffer[index], index incremented, added to sum mod 256; after the LEN-th byte -> CHK.
REQ-012 CHK: byte equals sum -> HOLD, frame_valid_o = 1 the cycle after the CHK tick; mismatch -> pulse err_chk_o, go IDLE.
REQ-013 HOLD: frame_valid_o and frame_len_o SHALL stay stable until frame_ack_i is sampled high, then go IDLE with frame_valid_o = 0 the following cycle.
REQ-014 In HOLD, rx_done_tick_i SHALL NOT modify the buffer; each such byte pulses err_ovf_o and is discarded. The one exception: frame_ack_i and rx_done_tick_i in the same cycle -> ack wins, the byte is processed as in IDLE.
REQ-015 Timeout counter SHALL run in LEN, PAYLOAD and CHK, clear on every rx_done_tick_i and on state entry; at c_tout_bits*c_clkfreq/c_baudrate cycles -> pulse err_tout_o, go IDLE.
REQ-016 A 0xA5 byte received in LEN, PAYLOAD or CHK SHALL be treated as data, not as a resync.
REQ-017 rd_data_o SHALL equal buffer[rd_addr_i] one cycle after rd_addr_i is presented. Reads at rd_addr_i >= c_max_len SHALL return 0x00. Reads are valid in every state; contents are guaranteed only in HOLD.
REQ-018 Error pulses SHALL be exactly one clk wide and mutually exclusive per cycle.
REQ-019 The running sum SHALL be 8 bits and wrap modulo 256. The byte index SHALL be wide enough for c_max_len.

Reset
REQ-020 While rst_n = 0 the FSM SHALL be IDLE, and frame_valid_o, frame_len_o, rd_data_o, all err_*_o, the counters and the sum SHALL be 0. Buffer contents need not be cleared.
REQ-021 Reset asserted mid-frame or in HOLD SHALL abandon the frame immediately. After release, the block SHALL wait for a fresh 0xA5.

Verification
REQ-022 Bytes A5 03 D2 01 FF D5 -> frame_valid_o = 1, frame_len_o = 3; reading addr 0/1/2 returns D2/01/FF; frame_ack_i -> frame_valid_o = 0 next cycle.
REQ-023 Bytes A5 03 D2 01 FF D4 -> one err_chk_o pulse, frame_valid_o stays 0; following A5 01 7F 80 -> valid frame, len 1, data 7F.
REQ-024 Bytes A5 00, then A5 11 (c_max_len = 16) -> two err_len_o pulses, no frame.
REQ-025 Bytes A5 02 33, then line idle > 20 bit periods (17361 clk at 100 MHz/115200) -> one err_tout_o pulse, FSM back to IDLE.
REQ-026 While holding a frame, send byte 55 -> err_ovf_o pulse, buffer unchanged. Then send A5 in the same cycle as frame_ack_i -> no err_ovf_o, the next frame is parsed normally.
REQ-027 Assert rst_n = 0 after A5 02 11 -> all outputs 0. After release, bytes 22 33 produce no frame and no error.
